param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/param_updown_counter.sv | 68 ++++++
 tb/tb_param_updown_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parameterized up/down counter with parallel load, wrap or saturate at the
// range ends, a combinational terminal-count flag and a registered wrap pulse.
module param_updown_counter #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter bit                   SATURATE  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             terminal_count,
  output logic             wrap
);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] counter_next;
  logic             wrap_next;

  assign at_max  = (counter == MAX_VAL);
  assign at_zero = (counter == '0);

  assign terminal_count = (up_down & at_max) | (~up_down & at_zero);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    counter_next = counter;
    wrap_next    = 1'b0;
    if (load) begin
      // Out-of-range load values are clamped so counter never exceeds MAX_VAL.
      counter_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (!at_max) begin
          counter_next = counter + 1'b1;
        end else if (!SATURATE) begin
          counter_next = '0;
          wrap_next    = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          counter_next = counter - 1'b1;
        end else if (!SATURATE) begin
          counter_next = MAX_VAL;
          wrap_next    = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter <= RESET_VAL;
      wrap    <= 1'b0;
    end else begin
      counter <= counter_next;
      wrap    <= wrap_next;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Randomized and directed bench for param_updown_counter: a wrapping and a
// saturating instance share stimulus and are compared against a range model.
module tb_param_updown_counter;

  localparam int MAXV = 9;
  localparam int RST_W = 0;
  localparam int RST_S = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;

  logic [3:0] counter_w, counter_s;
  logic       tc_w, tc_s, wrap_w, wrap_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: index 0 = wrapping instance, 1 = saturating instance.
  int m_cnt [2];
  int m_wrap[2];

  always #5 clock = ~clock;

  param_updown_counter #(
    .WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'(RST_W)), .SATURATE(1'b0)
  ) dut_wrap (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .counter(counter_w),
    .terminal_count(tc_w), .wrap(wrap_w)
  );

  param_updown_counter #(
    .WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'(RST_S)), .SATURATE(1'b1)
  ) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .counter(counter_s),
    .terminal_count(tc_s), .wrap(wrap_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_tc(input int c, input logic ud);
    return (ud && c == MAXV) || (!ud && c == 0) ? 1 : 0;
  endfunction

  // Range rules: wrap mode counts modulo MAXV+1, saturate mode clamps to 0..MAXV.
  task automatic model_edge(input logic en, input logic ud, input logic ld, input int lv);
    for (int i = 0; i < 2; i++) begin
      m_wrap[i] = 0;
      if (ld) begin
        m_cnt[i] = (lv > MAXV) ? MAXV : lv;
      end else if (en) begin
        if (i == 1) begin
          m_cnt[i] = ud ? ((m_cnt[i] + 1 > MAXV) ? MAXV : m_cnt[i] + 1)
                        : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
        end else begin
          m_wrap[i] = ud ? int'(m_cnt[i] == MAXV) : int'(m_cnt[i] == 0);
          m_cnt[i]  = ud ? (m_cnt[i] + 1) % (MAXV + 1)
                         : (m_cnt[i] + MAXV) % (MAXV + 1);
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_cnt_w"},  counter_w, m_cnt[0]);
    check({tag, "_wrap_w"}, wrap_w,    m_wrap[0]);
    check({tag, "_tc_w"},   tc_w,      exp_tc(m_cnt[0], up_down));
    check({tag, "_cnt_s"},  counter_s, m_cnt[1]);
    check({tag, "_wrap_s"}, wrap_s,    m_wrap[1]);
    check({tag, "_tc_s"},   tc_s,      exp_tc(m_cnt[1], up_down));
  endtask

  // Called just after a falling edge: drive, check tc live, clock, check result.
  task automatic step(input string tag, input logic en, input logic ud,
                      input logic ld, input logic [3:0] lv);
    enable = en; up_down = ud; load = ld; load_value = lv;
    #1;
    check({tag, "_tc_pre_w"}, tc_w, exp_tc(m_cnt[0], ud));
    check({tag, "_tc_pre_s"}, tc_s, exp_tc(m_cnt[1], ud));
    @(posedge clock);
    model_edge(en, ud, ld, int'(lv));
    @(negedge clock);
    check_outputs(tag);
  endtask

  // Asserts reset mid-cycle and checks the outputs before any clock edge.
  task automatic async_reset(input string tag);
    reset = 1'b0;
    #1;
    m_cnt[0] = RST_W; m_cnt[1] = RST_S;
    m_wrap[0] = 0;    m_wrap[1] = 0;
    check_outputs(tag);
    @(negedge clock);
    check_outputs({tag, "_hold"});
    reset = 1'b1;
  endtask

  initial begin
    m_cnt[0] = RST_W; m_cnt[1] = RST_S;
    m_wrap[0] = 0;    m_wrap[1] = 0;
    repeat (2) @(negedge clock);
    check_outputs("reset");
    reset = 1'b1;

    // Down-count wrap from 0: 9,8,...,0,9.
    for (int i = 0; i < 11; i++) step("down", 1'b1, 1'b0, 1'b0, 4'd0);
    check("down_end_w", counter_w, 9);

    // Up-count from 0 for 12 clocks: 1..9,0,1,2.
    step("ld0", 1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 12; i++) step("up", 1'b1, 1'b1, 1'b0, 4'd0);
    check("up_end_w", counter_w, 2);

    // Saturation from 7: 8,9,9,9.
    step("ld7", 1'b0, 1'b1, 1'b1, 4'd7);
    for (int i = 0; i < 4; i++) step("sat", 1'b1, 1'b1, 1'b0, 4'd0);
    check("sat_end_s", counter_s, 9);

    // Load priority and clamp.
    step("ld14", 1'b1, 1'b1, 1'b1, 4'd14);
    check("clamp_w", counter_w, 9);
    step("ld5", 1'b0, 1'b0, 1'b1, 4'd5);
    check("ld5_w", counter_w, 5);

    // Async reset mid-count at 6.
    step("ld6", 1'b0, 1'b1, 1'b1, 4'd6);
    async_reset("arst");
    step("resume", 1'b1, 1'b1, 1'b0, 4'd0);
    check("resume_w", counter_w, 1);

    // Direction flip at 4 and hold.
    step("ld4", 1'b0, 1'b1, 1'b1, 4'd4);
    step("flip_up", 1'b1, 1'b1, 1'b0, 4'd0);
    step("flip_dn", 1'b1, 1'b0, 1'b0, 4'd0);
    step("flip_dn", 1'b1, 1'b0, 1'b0, 4'd0);
    check("flip_w", counter_w, 3);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b1, 1'b0, 4'd0);
    check("hold_w", counter_w, 3);

    // Randomized traffic with occasional loads and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      end
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
